// File: rtl/layer_link_if.sv
// Handshake and vector bus between one layer_link and the two matrix-multiply
// layers on either side of it.
interface layer_link_if #(
  parameter int PK_WIDTH = 7,
  parameter int PK_LEN   = 9
);
  logic                         up_valid;
  logic [PK_WIDTH*PK_LEN-1:0]   up_packed_in;
  logic                         up_ack;
  logic [PK_WIDTH*PK_LEN-1:0]   up_packed_out;
  logic                         up_backprop;
  logic                         dn_valid;
  logic [PK_WIDTH*PK_LEN-1:0]   dn_packed_in;
  logic                         dn_ack;
  logic [PK_WIDTH*PK_LEN-1:0]   dn_packed_out;
  logic                         dn_mult;

  modport master (
    output up_valid, up_packed_in, dn_valid, dn_packed_in,
    input  up_ack, up_packed_out, up_backprop, dn_ack, dn_packed_out, dn_mult
  );

  modport slave (
    input  up_valid, up_packed_in, dn_valid, dn_packed_in,
    output up_ack, up_packed_out, up_backprop, dn_ack, dn_packed_out, dn_mult
  );
endinterface

// File: rtl/layer_link.sv
// Bridge between two adjacent layers: buffers the forward activation and the
// backward delta, sequencing mult/backprop strobes with a watchdog.
module layer_link #(
  parameter int PK_WIDTH    = 7,
  parameter int PK_LEN      = 9,
  parameter int DELTA_SHIFT = 0,
  parameter int TIMEOUT     = 255
) (
  input  logic         clk,
  input  logic         reset,
  layer_link_if.slave  lnk,
  output logic         err,
  output logic [15:0]  samples_done
);
  localparam int VEC_W = PK_WIDTH * PK_LEN;
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, FWD_ACK, FWD_DROP, MULT, SKIP_HI, SKIP_LO,
    BWD_CAP, BWD_ACK, BWD_DROP, BACKPROP, ERROR
  } state_t;

  state_t             state_q, state_d;
  logic [VEC_W-1:0]   fwd_buf_q, fwd_buf_d;
  logic [VEC_W-1:0]   bwd_buf_q, bwd_buf_d;
  logic               err_q, err_d;
  logic [15:0]        samples_q, samples_d;
  logic [7:0]         wd_q, wd_d;
  logic               wd_hold;

  function automatic logic [VEC_W-1:0] scale_delta(input logic [VEC_W-1:0] v);
    logic signed [PK_WIDTH-1:0] e;
    scale_delta = '0;
    for (int i = 0; i < PK_LEN; i++) begin
      e = v[i*PK_WIDTH +: PK_WIDTH];
      scale_delta[i*PK_WIDTH +: PK_WIDTH] = e >>> DELTA_SHIFT;
    end
  endfunction

  always_comb begin
    state_d   = state_q;
    fwd_buf_d = fwd_buf_q;
    bwd_buf_d = bwd_buf_q;
    err_d     = err_q;
    samples_d = samples_q;
    wd_d      = '0;
    wd_hold   = 1'b0;
    case (state_q)
      IDLE:     if (lnk.up_valid) begin
                  fwd_buf_d = lnk.up_packed_in;
                  state_d   = FWD_ACK;
                end
      FWD_ACK:  state_d = FWD_DROP;
      FWD_DROP: if (!lnk.up_valid) state_d = MULT; else wd_hold = 1'b1;
      MULT:     state_d = SKIP_HI;
      // The downstream forward result is for the next link; only watch it pass.
      SKIP_HI:  if (lnk.dn_valid) state_d = SKIP_LO; else wd_hold = 1'b1;
      SKIP_LO:  if (!lnk.dn_valid) state_d = BWD_CAP;
      BWD_CAP:  if (lnk.dn_valid) begin
                  bwd_buf_d = scale_delta(lnk.dn_packed_in);
                  state_d   = BWD_ACK;
                end
      BWD_ACK:  state_d = BWD_DROP;
      BWD_DROP: if (!lnk.dn_valid) state_d = BACKPROP; else wd_hold = 1'b1;
      BACKPROP: begin
                  samples_d = samples_q + 16'd1;
                  state_d   = IDLE;
                end
      ERROR:    state_d = ERROR;
      default:  state_d = IDLE;
    endcase
    // Counter only survives while parked in a bounded wait state.
    if (wd_hold) begin
      if (wd_q == WD_LAST) begin
        state_d = ERROR;
        err_d   = 1'b1;
      end else begin
        wd_d = wd_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      fwd_buf_q <= '0;
      bwd_buf_q <= '0;
      err_q     <= 1'b0;
      samples_q <= '0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      fwd_buf_q <= fwd_buf_d;
      bwd_buf_q <= bwd_buf_d;
      err_q     <= err_d;
      samples_q <= samples_d;
      wd_q      <= wd_d;
    end
  end

  assign lnk.up_ack        = (state_q == FWD_ACK);
  assign lnk.dn_mult       = (state_q == MULT);
  assign lnk.dn_ack        = (state_q == BWD_ACK);
  assign lnk.up_backprop   = (state_q == BACKPROP);
  assign lnk.dn_packed_out = fwd_buf_q;
  assign lnk.up_packed_out = bwd_buf_q;
  assign err               = err_q;
  assign samples_done      = samples_q;
endmodule
